niu32_mem_arbiter: RTL and testbench
====================================

# niu32_mem_arbiter

Single-port memory arbiter for the Niu32 multicycle core. It shares one word-wide memory port between two requesters: the instruction-fetch path (IF) and the load/store path (LS). It serialises their accesses and inserts a programmable number of memory wait cycles. It returns read data and a one-cycle completion pulse to whichever requester was granted.

## Interface
- WORD_SIZE, 32, data and address width in bits
- WAIT_CYCLES, 1, cycles `mem_en` is held per access; legal range 1..15
- clk  in  1  system clock, all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until `if_done`
- if_addr  in  WORD_SIZE  fetch byte address
- if_gnt  out  1  high while the IF access owns the memory port
- if_done  out  1  one-cycle completion pulse for IF
- if_err  out  1  coincides with `if_done` when the access was misaligned
- ls_req  in  1  load/store request; held high until `ls_done`
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  WORD_SIZE  load/store byte address
- ls_wdata  in  WORD_SIZE  store data
- ls_gnt, ls_done, ls_err  out  1 each  LS equivalents of the IF signals
- rdata  out  WORD_SIZE  last captured read word, shared by both requesters
- mem_en, mem_we  out  1 each  memory strobe and write enable
- mem_addr, mem_wdata  out  WORD_SIZE  latched access address and write data
- mem_rdata  in  WORD_SIZE  memory read data, valid in the last `mem_en` cycle

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - Samples `if_req` and `ls_req`.
  - If neither is high, stays in IDLE.
  - If exactly one is high, that requester wins.
  - If both are high, the winner is set by the priority rule in Configuration.
  - On a win, latches the winner's address, we and wdata (we = 0 for IF) and loads the counter with WAIT_CYCLES-1.
  - If the latched address has [1:0] ≠ 0, goes straight to DONE with the err flag set and no memory strobe.
  - Otherwise goes to ACCESS.
- **ACCESS**
  - Drives `mem_en`=1, `mem_we`=latched we, `mem_addr`/`mem_wdata` from the latched values, and the winner's gnt=1.
  - Counter decrements each cycle.
  - When the counter is 0, captures `mem_rdata` into `rdata` (loads only; stores leave `rdata` unchanged) and moves to DONE.
- **DONE**
  - Winner's done=1 (plus err if flagged); all mem outputs are 0.
  - Updates the last-served register.
  - Always moves to IDLE.
- Request inputs are ignored outside IDLE. A requester dropping req mid-access does not abort it: the access completes and done still pulses.
- A request still high in the IDLE cycle after done is treated as a new request. Requesters deassert req on the edge that ends the done cycle.
- Reset (asynchronous, any state): FSM→IDLE, counter=0, last-served=IF. All outputs are 0: gnt, done, err, mem_en, mem_we, mem_addr, mem_wdata, and `rdata`=0. An access in flight is discarded with no done pulse.

## Timing
- Requests are sampled at rising edge k. ACCESS occupies cycles k..k+W-1, with W=WAIT_CYCLES.
- `mem_rdata` is captured at edge k+W. done is high in the cycle after edge k+W. IDLE is reached at edge k+W+1.
- The earliest following grant is at edge k+W+2. Throughput is one access per W+2 cycles.
- A misaligned request gives done+err in the cycle after edge k, then IDLE at k+1.
- gnt and mem_en are asserted in exactly the same cycles. gnt is never high for both requesters at once.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `NIU32_ARB_FAIR_EN` defined:
  - On simultaneous requests, the requester not served most recently wins (alternating).
  - After reset last-served=IF, so the first conflict goes to LS.
- Not defined: fixed priority, LS always wins a conflict, and the last-served register is not implemented.
- With only one requester active, both builds behave the same.

## Test plan
- W=2, `if_req` alone, `if_addr`=0x10, `mem_rdata`=0xDEADBEEF → `mem_en` high for 2 cycles with `mem_addr`=0x10; `if_done` 1 cycle; `rdata`=0xDEADBEEF; `if_err`=0.
- W=2, LS store, `ls_addr`=0x20, `ls_wdata`=0x1234 → `mem_we`=1 for 2 cycles; `ls_done` pulses; `rdata` keeps its previous value.
- Both requesters held high for 4 accesses:
  - FAIR_EN build: grant order LS, IF, LS, IF.
  - Non-FAIR build: LS is served every time, IF never.
- `ls_addr`=0x22 → no `mem_en`; `ls_done` and `ls_err` high in the cycle after the sample edge.
- Reset asserted in the second ACCESS cycle → all outputs 0 immediately (asynchronously); no done pulse. After release, a new `if_req` is granted normally.
- `if_req` dropped during ACCESS → the access still completes and `if_done` pulses once.

Source files
------------

// File: rtl/niu32_mem_arbiter.sv
// niu32_mem_arbiter: shares one memory port between fetch (IF) and load/store (LS) with WAIT_CYCLES wait states.
// Define NIU32_ARB_FAIR_EN for alternating priority on conflicts; otherwise LS always wins.
module niu32_mem_arbiter #(
    parameter int WORD_SIZE   = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_if_req,
    input  logic [WORD_SIZE-1:0] i_if_addr,
    output logic                 o_if_gnt,
    output logic                 o_if_done,
    output logic                 o_if_err,
    input  logic                 i_ls_req,
    input  logic                 i_ls_we,
    input  logic [WORD_SIZE-1:0] i_ls_addr,
    input  logic [WORD_SIZE-1:0] i_ls_wdata,
    output logic                 o_ls_gnt,
    output logic                 o_ls_done,
    output logic                 o_ls_err,
    output logic [WORD_SIZE-1:0] o_rdata,
    output logic                 o_mem_en,
    output logic                 o_mem_we,
    output logic [WORD_SIZE-1:0] o_mem_addr,
    output logic [WORD_SIZE-1:0] o_mem_wdata,
    input  logic [WORD_SIZE-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic   [3:0]           r_cnt;
    logic                   r_sel;
    logic                   r_we;
    logic                   r_err;
    logic   [WORD_SIZE-1:0] r_addr;
    logic   [WORD_SIZE-1:0] r_wdata;
    logic   [WORD_SIZE-1:0] r_rdata;
    logic                   w_ls_prio;
    logic                   w_any;
    logic                   w_pick_ls;
    logic   [WORD_SIZE-1:0] w_addr;
    logic                   w_mis;

`ifdef NIU32_ARB_FAIR_EN
    logic r_last;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_last <= 1'b0;
        else if (r_state == S_DONE)
            r_last <= r_sel;
    end
    assign w_ls_prio = ~r_last;
`else
    assign w_ls_prio = 1'b1;
`endif

    assign w_any     = i_if_req | i_ls_req;
    assign w_pick_ls = i_ls_req & (~i_if_req | w_ls_prio);
    assign w_addr    = w_pick_ls ? i_ls_addr : i_if_addr;
    assign w_mis     = |w_addr[1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == S_IDLE)   ? (w_any ? (w_mis ? S_DONE : S_ACCESS) : S_IDLE) :
                 (r_state == S_ACCESS) ? ((r_cnt == 4'd0) ? S_DONE : S_ACCESS) : S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_cnt   <= 4'(WAIT_CYCLES - 1);
            r_sel   <= w_pick_ls;
            r_we    <= w_pick_ls & i_ls_we;
            r_err   <= w_mis;
            r_addr  <= w_addr;
            r_wdata <= w_pick_ls ? i_ls_wdata : '0;
        end else if (r_state == S_ACCESS) begin
            if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            else if (!r_we)
                r_rdata <= i_mem_rdata;
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        o_if_gnt    = (r_state == S_ACCESS) & ~r_sel;
        o_ls_gnt    = (r_state == S_ACCESS) & r_sel;
        o_if_done   = (r_state == S_DONE) & ~r_sel;
        o_ls_done   = (r_state == S_DONE) & r_sel;
        o_if_err    = o_if_done & r_err;
        o_ls_err    = o_ls_done & r_err;
        o_mem_en    = (r_state == S_ACCESS);
        o_mem_we    = o_mem_en & r_we;
        o_mem_addr  = o_mem_en ? r_addr : '0;
        o_mem_wdata = o_mem_en ? r_wdata : '0;
        o_rdata     = r_rdata;
    end
endmodule

// File: tb/tb_niu32_mem_arbiter.sv
// tb_niu32_mem_arbiter: directed checks of the memory arbiter with WAIT_CYCLES=2.
module tb_niu32_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic        if_gnt, if_done, if_err, ls_gnt, ls_done, ls_err, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    int          checks = 0;
    int          errors = 0;

    niu32_mem_arbiter #(.WORD_SIZE(32), .WAIT_CYCLES(2)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(if_gnt), .o_if_done(if_done), .o_if_err(if_err),
        .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
        .o_ls_gnt(ls_gnt), .o_ls_done(ls_done), .o_ls_err(ls_err),
        .o_rdata(rdata), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [103:0] all_out();
        return {if_gnt, if_done, if_err, ls_gnt, ls_done, ls_err, mem_en, mem_we, rdata, mem_addr, mem_wdata};
    endfunction

    task automatic test_reset();
        rst = 1'b1; if_req = 0; ls_req = 0; ls_we = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0;
        tick(); tick();
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out()); end
        rst = 1'b0;
        tick();
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL reset_idle: got %h expected 0", all_out()); end
    endtask

    task automatic test_if_read();
        if_req = 1; if_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        tick();
        checks++; if ({if_gnt, ls_gnt, mem_en, mem_we} !== 4'b1010) begin errors++; $display("FAIL if_read_c1: got %b expected 1010", {if_gnt, ls_gnt, mem_en, mem_we}); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL if_read_addr: got %h expected 00000010", mem_addr); end
        tick();
        checks++; if ({if_gnt, mem_en, if_done} !== 3'b110) begin errors++; $display("FAIL if_read_c2: got %b expected 110", {if_gnt, mem_en, if_done}); end
        tick();
        checks++; if ({if_gnt, mem_en, if_done, if_err} !== 4'b0010) begin errors++; $display("FAIL if_read_done: got %b expected 0010", {if_gnt, mem_en, if_done, if_err}); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL if_read_rdata: got %h expected deadbeef", rdata); end
        if_req = 0;
        tick();
        checks++; if ({if_done, mem_en} !== 2'b00) begin errors++; $display("FAIL if_read_idle: got %b expected 00", {if_done, mem_en}); end
    endtask

    task automatic test_ls_store();
        ls_req = 1; ls_we = 1; ls_addr = 32'h20; ls_wdata = 32'h1234; mem_rdata = 32'h55555555;
        tick();
        checks++; if ({ls_gnt, if_gnt, mem_en, mem_we} !== 4'b1011) begin errors++; $display("FAIL store_c1: got %b expected 1011", {ls_gnt, if_gnt, mem_en, mem_we}); end
        checks++; if ({mem_addr, mem_wdata} !== {32'h20, 32'h1234}) begin errors++; $display("FAIL store_bus: got %h expected 0000002000001234", {mem_addr, mem_wdata}); end
        tick();
        checks++; if ({ls_gnt, mem_we} !== 2'b11) begin errors++; $display("FAIL store_c2: got %b expected 11", {ls_gnt, mem_we}); end
        tick();
        checks++; if ({ls_done, ls_err, mem_en, mem_we} !== 4'b1000) begin errors++; $display("FAIL store_done: got %b expected 1000", {ls_done, ls_err, mem_en, mem_we}); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_rdata: got %h expected deadbeef", rdata); end
        ls_req = 0; ls_we = 0;
        tick();
        checks++; if (ls_done !== 1'b0) begin errors++; $display("FAIL store_idle: got %b expected 0", ls_done); end
    endtask

    task automatic test_misaligned();
        ls_req = 1; ls_addr = 32'h22;
        tick();
        checks++; if ({ls_done, ls_err, mem_en, ls_gnt} !== 4'b1100) begin errors++; $display("FAIL misalign_done: got %b expected 1100", {ls_done, ls_err, mem_en, ls_gnt}); end
        ls_req = 0;
        tick();
        checks++; if ({ls_done, ls_err, mem_en} !== 3'b000) begin errors++; $display("FAIL misalign_idle: got %b expected 000", {ls_done, ls_err, mem_en}); end
    endtask

    task automatic test_conflict();
        logic [3:0] exp_ls;
`ifdef NIU32_ARB_FAIR_EN
        exp_ls = 4'b0101;
`else
        exp_ls = 4'b1111;
`endif
        rst = 1; #1; rst = 0;
        if_req = 1; if_addr = 32'h40; ls_req = 1; ls_we = 0; ls_addr = 32'h80; mem_rdata = 32'hA5A5A5A5;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++; if ({ls_gnt, if_gnt} !== {exp_ls[n], ~exp_ls[n]}) begin errors++; $display("FAIL conflict_gnt%0d: got ls/if %b expected %b", n, {ls_gnt, if_gnt}, {exp_ls[n], ~exp_ls[n]}); end
            checks++; if (mem_addr !== (exp_ls[n] ? 32'h80 : 32'h40)) begin errors++; $display("FAIL conflict_addr%0d: got %h expected %h", n, mem_addr, exp_ls[n] ? 32'h80 : 32'h40); end
            tick(); tick();
            checks++; if ({ls_done, if_done} !== {exp_ls[n], ~exp_ls[n]}) begin errors++; $display("FAIL conflict_done%0d: got %b expected %b", n, {ls_done, if_done}, {exp_ls[n], ~exp_ls[n]}); end
            if (n == 3) begin if_req = 0; ls_req = 0; end
            tick();
        end
        checks++; if ({if_gnt, ls_gnt, mem_en} !== 3'b000) begin errors++; $display("FAIL conflict_end: got %b expected 000", {if_gnt, ls_gnt, mem_en}); end
    endtask

    task automatic test_reset_mid();
        if_req = 1; if_addr = 32'h10; mem_rdata = 32'h0BADF00D;
        tick(); tick();
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", mem_en); end
        rst = 1; #1;
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL rstmid_async: got %h expected 0", all_out()); end
        tick();
        checks++; if ({if_done, ls_done} !== 2'b00) begin errors++; $display("FAIL rstmid_nodone: got %b expected 00", {if_done, ls_done}); end
        rst = 0;
        tick();
        checks++; if ({if_gnt, mem_en, mem_addr} !== {2'b11, 32'h10}) begin errors++; $display("FAIL rstmid_regrant: got %h expected 3_00000010", {if_gnt, mem_en, mem_addr}); end
        tick(); tick();
        checks++; if ({if_done, rdata} !== {1'b1, 32'h0BADF00D}) begin errors++; $display("FAIL rstmid_done: got %h expected 1_0badf00d", {if_done, rdata}); end
        if_req = 0;
        tick();
    endtask

    task automatic test_drop_mid();
        int dones = 0;
        if_req = 1; if_addr = 32'h30; mem_rdata = 32'h13579BDF;
        tick();
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL drop_gnt: got %b expected 1", if_gnt); end
        if_req = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            dones += int'(if_done);
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL drop_done_count: got %0d expected 1", dones); end
        checks++; if (rdata !== 32'h13579BDF) begin errors++; $display("FAIL drop_rdata: got %h expected 13579bdf", rdata); end
        checks++; if ({if_gnt, mem_en} !== 2'b00) begin errors++; $display("FAIL drop_idle: got %b expected 00", {if_gnt, mem_en}); end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_ls_store();
        test_misaligned();
        test_conflict();
        test_reset_mid();
        test_drop_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
